guess_game_scored: RTL
======================

GUESS_GAME_SCORED -- requirements
Module: guess_game_scored

Interface
REQ-001 Parameter N, default 4: number of buttons and LEDs; the design SHALL support N from 2 to 16.
REQ-002 Parameter CNT_W, default 4: width of each score counter; the design SHALL support CNT_W from 1 to 16.
REQ-003 clk  input  1: single clock; all state SHALL change on the rising edge.
REQ-004 rst  input  1: asynchronous, active-high reset.
REQ-005 en  input  1: one-cycle advance tick, synchronous to clk.
REQ-006 in  input  N: button levels; bit i is button i.
REQ-007 dir  input  1: rotation direction; 0 = toward higher bit index, 1 = toward lower bit index.
REQ-008 y  output  N: one-hot LED pattern showing the current target position.
REQ-009 win  output  1: high while the state is WIN.
REQ-010 lose  output  1: high while the state is LOSE.
REQ-011 win_cnt  output  CNT_W: saturating count of wins.
REQ-012 lose_cnt  output  CNT_W: saturating count of losses.

Function
REQ-013 The FSM SHALL have exactly three states: RUN, WIN and LOSE.
REQ-014 A position register pos, range 0..N-1, SHALL drive y; y SHALL equal 1<<pos in every state, and all outputs SHALL be registered or decoded from registers only.
REQ-015 In RUN with in==0 and en=1, pos SHALL advance one step per tick, with wrap-around.
REQ-016 Direction rule: with dir=0, pos SHALL go pos+1 and wrap N-1 -> 0; with dir=1, pos SHALL go pos-1 and wrap 0 -> N-1.
REQ-017 dir SHALL be sampled only on ticks where the advance actually occurs.
REQ-018 In RUN with in==0 and en=0, pos SHALL hold.
REQ-019 In RUN with in!=0 and in==y, the next state SHALL be WIN and win_cnt SHALL increment at the same edge.
REQ-020 In RUN with in!=0 and in!=y, the next state SHALL be LOSE and lose_cnt SHALL increment at the same edge.
REQ-021 The in!=y rule SHALL cover multiple buttons pressed, including any pattern that contains the correct bit.
REQ-022 Latency: win/lose SHALL assert, and the counter SHALL show its new value, one clk edge after the press is first sampled.
REQ-023 Simultaneous press and en in RUN: the press SHALL take priority, pos SHALL NOT advance, and the comparison SHALL use the pre-edge y.
REQ-024 In WIN or LOSE, pos SHALL be frozen regardless of en and dir, and neither counter SHALL change while in stays nonzero.
REQ-025 One score per press: a button held across many cycles SHALL be counted once.
REQ-026 Leaving WIN or LOSE SHALL require in==0, sampled at an edge, and the next state SHALL be RUN.
REQ-027 The edge that returns to RUN SHALL NOT advance pos, even if en=1 at that edge.
REQ-028 win and lose SHALL never be high together.
REQ-029 Saturation: a counter at 2^CNT_W-1 SHALL hold that value on further wins or losses; there SHALL be no wrap.
REQ-030 in is assumed to be already synchronised and debounced upstream; the block SHALL NOT filter in.

Reset
REQ-031 While rst=1, asynchronously: state=RUN, pos=0 (y=1), win=0, lose=0, win_cnt=0, lose_cnt=0.
REQ-032 Asserting rst in WIN or LOSE SHALL clear everything in REQ-031 immediately, without waiting for a clock edge.
REQ-033 After rst deasserts, the first edge SHALL behave as RUN with pos=0.

Verification (N=4, CNT_W=4 unless stated)
REQ-034 Reset: rst pulse, in=0 -> y=0001, win=0, lose=0, win_cnt=0, lose_cnt=0, with no clock edge needed.
REQ-035 Rotation and wrap: dir=0 with 4 en ticks -> y goes 0010, 0100, 1000, 0001; then dir=1 with 1 tick -> y=1000.
REQ-036 Win with hold: at y=0010 apply in=0010 for 6 cycles with en toggling -> win=1 from edge 1, win_cnt=1 and y=0010 throughout; then in=0 -> next edge win=0 and state RUN, y still 0010.
REQ-037 Lose on multi-press: at y=0001 apply in=0011 -> next edge lose=1, lose_cnt=1, win_cnt unchanged.
REQ-038 Press coincident with en: at y=0100 apply in=0100 with en=1 at the same edge -> win=1, y=0100, and no advance on the release edge.
REQ-039 Saturation and reset: with CNT_W=2, 5 win/release cycles -> win_cnt=3; then assert rst while win=1 -> win=0 and win_cnt=0 immediately.

Source files
------------

// File: rtl/guess_game_scored.sv
// Reaction game: a single lit LED rotates, and a button press scores a win or a loss.
// Win and loss counts saturate. The WIN/LOSE state is held until every button is released.
module guess_game_scored #(
    parameter int N     = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N-1:0]     in,
    input  logic             dir,
    output logic [N-1:0]     y,
    output logic             win,
    output logic             lose,
    output logic [CNT_W-1:0] win_cnt,
    output logic [CNT_W-1:0] lose_cnt
);

    localparam int PW = $clog2(N);

    localparam logic [1:0] RUN  = 2'd0;
    localparam logic [1:0] WIN  = 2'd1;
    localparam logic [1:0] LOSE = 2'd2;

    localparam logic [PW-1:0]    POS_MAX = PW'(N - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]    state;
    logic [PW-1:0] pos;
    logic [PW-1:0] pos_next;

    always_comb begin
        pos_next = pos;
        if (dir) begin
            pos_next = (pos == '0) ? POS_MAX : pos - PW'(1);
        end else begin
            pos_next = (pos == POS_MAX) ? '0 : pos + PW'(1);
        end
    end

    // A press outranks a coincident tick and is judged against the LED shown before the edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            pos      <= '0;
            win_cnt  <= '0;
            lose_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (in != '0) begin
                        if (in == y) begin
                            state <= WIN;
                            if (win_cnt != CNT_MAX) win_cnt <= win_cnt + CNT_W'(1);
                        end else begin
                            state <= LOSE;
                            if (lose_cnt != CNT_MAX) lose_cnt <= lose_cnt + CNT_W'(1);
                        end
                    end else if (en) begin
                        pos <= pos_next;
                    end
                end
                WIN, LOSE: begin
                    if (in == '0) state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

    assign y    = N'(1) << pos;
    assign win  = (state == WIN);
    assign lose = (state == LOSE);

endmodule
